// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and default widths for the EX/MEM stage
package cpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 6;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_JUMP = 2'b01,
        BR_BRZ  = 2'b10,
        BR_BRN  = 2'b11
    } br_type_e;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] result;
        logic [REG_AW_DEF-1:0] rd;
        logic                  reg_we;
        logic                  mem_we;
        logic                  mem_re;
    } ex_mem_payload_t;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - resolves branch type against the stored Z/N flags
module branch_cond
    import cpu_pkg::*;
(
    input  logic [1:0] br_type,
    input  logic       flag_z,
    input  logic       flag_n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_JUMP: taken = 1'b1;
            BR_BRZ:  taken = flag_z;
            BR_BRN:  taken = flag_n;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM register, Z/N flags and branch redirect
// Optional perf_retired/perf_taken counters when EX_PERF_CNT_EN is defined.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_z,
    input  logic              in_n,
    input  logic              in_flag_we,
    input  logic [1:0]        in_br_type,
    input  logic [DATA_W-1:0] in_target,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_we,
    input  logic              in_mem_we,
    input  logic              in_mem_re,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_we,
    output logic              out_mem_we,
    output logic              out_mem_re,
    output logic              flag_z,
    output logic              flag_n,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_taken
`endif
);

    logic accept;
    logic live;
    logic cond_taken;
    logic taken;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    // An instruction accepted while the redirect pulse is high is wrong-path.
    assign live     = accept & ~redirect_valid;
    assign taken    = live & cond_taken;

    branch_cond u_branch_cond (
        .br_type (in_br_type),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .taken   (cond_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_reg_we <= 1'b0;
            out_mem_we <= 1'b0;
            out_mem_re <= 1'b0;
        end else if (live) begin
            out_valid  <= 1'b1;
            out_result <= in_result;
            out_rd     <= in_rd;
            out_reg_we <= in_reg_we;
            out_mem_we <= in_mem_we;
            out_mem_re <= in_mem_re;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (live && in_flag_we) begin
            flag_z <= in_z;
            flag_n <= in_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= taken;
            if (taken) begin
                redirect_pc <= in_target;
            end
        end
    end

`ifdef EX_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= '0;
            perf_taken   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                perf_retired <= perf_retired + 32'd1;
            end
            if (redirect_valid) begin
                perf_taken <= perf_taken + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - scoreboard bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_z = 1'b0;
    logic        in_n = 1'b0;
    logic        in_flag_we = 1'b0;
    logic [1:0]  in_br_type = 2'b00;
    logic [31:0] in_target = '0;
    logic [5:0]  in_rd = '0;
    logic        in_reg_we = 1'b0;
    logic        in_mem_we = 1'b0;
    logic        in_mem_re = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [5:0]  out_rd;
    logic        out_reg_we;
    logic        out_mem_we;
    logic        out_mem_re;
    logic        flag_z;
    logic        flag_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [40:0] exp_q[$];
    logic [31:0] redir_q[$];

    ex_mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_z           (in_z),
        .in_n           (in_n),
        .in_flag_we     (in_flag_we),
        .in_br_type     (in_br_type),
        .in_target      (in_target),
        .in_rd          (in_rd),
        .in_reg_we      (in_reg_we),
        .in_mem_we      (in_mem_we),
        .in_mem_re      (in_mem_re),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_reg_we     (out_reg_we),
        .out_mem_we     (out_mem_we),
        .out_mem_re     (out_mem_re),
        .flag_z         (flag_z),
        .flag_n         (flag_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every drain handshake and every redirect pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {23'd0, out_result, out_rd, out_reg_we, out_mem_we, out_mem_re}, 64'hDEAD);
                end else begin
                    check("output_entry", {23'd0, out_result, out_rd, out_reg_we, out_mem_we, out_mem_re},
                          {23'd0, exp_q.pop_front()});
                end
            end
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    check("unexpected_redirect", {32'd0, redirect_pc}, 64'hDEAD);
                end else begin
                    check("redirect_pc", {32'd0, redirect_pc}, {32'd0, redir_q.pop_front()});
                end
            end
        end
    end

    task automatic drive(input logic [31:0] res, input logic [5:0] rd, input logic reg_we,
                         input logic mem_we, input logic mem_re, input logic flag_we,
                         input logic z, input logic n, input logic [1:0] br,
                         input logic [31:0] tgt, input bit exp_out, input bit exp_redir);
        in_valid   = 1'b1;
        in_result  = res;
        in_rd      = rd;
        in_reg_we  = reg_we;
        in_mem_we  = mem_we;
        in_mem_re  = mem_re;
        in_flag_we = flag_we;
        in_z       = z;
        in_n       = n;
        in_br_type = br;
        in_target  = tgt;
        if (exp_out) exp_q.push_back({res, rd, reg_we, mem_we, mem_re});
        if (exp_redir) redir_q.push_back(tgt);
    endtask

    task automatic wait_accept(output int stalls);
        bit seen = 0;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                seen = 1;
                break;
            end
            stalls++;
        end
        if (!seen) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int st;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_flags_redirect", {61'd0, flag_z, flag_n, redirect_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while stalled with a live entry and both flags set.
        out_ready = 1'b0;
        drive(32'h33, 6'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 0, 0);
        wait_accept(st);
        check("stall_out_valid", {63'd0, out_valid}, 64'd1);
        check("stall_flags", {62'd0, flag_z, flag_n}, 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", {23'd0, out_result, out_rd, out_reg_we, out_mem_we, out_mem_re}, 64'd0);
        check("midrst_valid_flags", {60'd0, out_valid, flag_z, flag_n, redirect_valid}, 64'd0);
        check("midrst_redirect_pc", {32'd0, redirect_pc}, 64'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);

        // Back-to-back stream with no backpressure.
        for (int i = 0; i < 3; i++) begin
            drive(32'(5 + i), 6'(1 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1, 0);
            wait_accept(st);
            check("stream_no_stall", 64'(st), 64'd0);
        end
        idle(2);

        // Backpressure holds the latched entry and blocks the next input.
        out_ready = 1'b0;
        drive(32'h12, 6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1, 0);
        wait_accept(st);
        drive(32'h13, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_result", {32'd0, out_result}, 64'h12);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(st);
        idle(2);

        // SUB producing zero, then BRZ taken to 0x40.
        drive(32'h0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 1, 0);
        wait_accept(st);
        drive(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h40, 1, 1);
        wait_accept(st);
        idle(3);

        // Clear Z, then BRZ not taken.
        drive(32'h9, 6'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 1, 0);
        wait_accept(st);
        drive(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'h44, 1, 0);
        wait_accept(st);
        idle(3);

        // Jump followed immediately by ADD r3: the ADD is squashed.
        drive(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h80, 1, 1);
        wait_accept(st);
        drive(32'h77, 6'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 0, 0);
        wait_accept(st);
        check("kill_reg_we", {63'd0, out_reg_we}, 64'd0);
        check("kill_flags", {62'd0, flag_z, flag_n}, 64'd0);
        idle(3);

        // Two taken jumps back-to-back: only the first redirects.
        drive(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h100, 1, 1);
        wait_accept(st);
        drive(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 32'h200, 0, 0);
        wait_accept(st);
        idle(3);

        // BRN that also writes N=1 resolves against the old N=0.
        drive(32'h0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 32'hC0, 1, 0);
        wait_accept(st);
        check("brn_flag_n_after", {63'd0, flag_n}, 64'd1);
        idle(4);

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("redir_queue_drained", 64'(redir_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage: sits directly downstream of the ALU and PC-target adder. Latches the ALU result and control into the EX/MEM register under a valid/ready handshake and holds the architectural Z/N flag register. Resolves jump/BRZ/BRN against the stored flags and issues a one-cycle PC redirect, squashing the wrong-path instruction arriving behind a taken branch.

## Interface
Parameters:
- DATA_W, 32, datapath width (ALU result, branch target)
- REG_AW, 6, destination register index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX instruction present
- in_ready  out  1  stage accepts this cycle
- in_result  in  DATA_W  ALU `out`
- in_z, in_n  in  1 each  ALU zero/negative flags
- in_flag_we  in  1  instruction writes flag register
- in_br_type  in  2  00 none, 01 jump, 10 BRZ, 11 BRN
- in_target  in  DATA_W  branch target (PC+imm or register value)
- in_rd  in  REG_AW  destination register
- in_reg_we, in_mem_we, in_mem_re  in  1 each  downstream control
- out_valid  out  1  EX/MEM register holds an instruction
- out_ready  in  1  MEM consumes this cycle
- out_result  out  DATA_W; out_rd  out  REG_AW; out_reg_we, out_mem_we, out_mem_re  out  1 each
- flag_z, flag_n  out  1 each  flag register
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  DATA_W  redirect target

## Operation
- in_ready = ~out_valid | out_ready (combinational); accept = in_valid & in_ready.
- Kill = redirect_valid high during an accept: instruction consumed and discarded (no register load, no flag update, no redirect).
- Live accept: EX/MEM register loads all in_* fields, out_valid<=1; branches pass through as register-write-free entries.
- No accept and out_ready: out_valid<=0. out_valid & ~out_ready: all outputs hold.
- Flags: live accept with in_flag_we loads flag_z<=in_z, flag_n<=in_n; otherwise hold.
- Branch condition uses flag values before this instruction's own update: jump always taken; BRZ taken iff flag_z; BRN taken iff flag_n; 00 never.
- Taken on live accept: next cycle redirect_valid=1, redirect_pc=in_target captured; pulse lasts exactly one cycle.
- Two back-to-back taken branches: second arrives during pulse, is killed; no second redirect.
- Reset (any time, including mid-stall): out_valid=0, out_result=0, out_rd=0, out_reg_we/mem_we/mem_re=0, flag_z=0, flag_n=0, redirect_valid=0, redirect_pc=0; in-flight entry lost.

## Timing
- Latency: accept at edge k -> out_* and flags valid after edge k, redirect_valid high in cycle k+1.
- Full throughput: one instruction per cycle while out_ready=1.
- in_ready depends only on out_valid/out_ready; no path from in_valid to in_ready.
- redirect_valid independent of out_ready: branch resolves at accept, not at drain.

## Configuration
- EX_PERF_CNT_EN defined: adds outputs perf_retired (32) and perf_taken (32); perf_retired increments on out_valid & out_ready, perf_taken on each redirect pulse; both wrap modulo 2^32, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- cpu_pkg: br_type enum (BR_NONE, BR_JUMP, BR_BRZ, BR_BRN), DATA_W/REG_AW defaults, EX/MEM payload struct.
- Sub-module branch_cond: combinational (br_type, flag_z, flag_n) -> taken.

## Test plan
- Reset mid-stall (out_valid=1, out_ready=0, flags set) -> all outputs 0 immediately on rst_n low.
- Stream result 5,6,7 with out_ready=1 -> out_result 5,6,7 on consecutive cycles, in_ready stays 1.
- Hold out_ready=0 two cycles with result 0x12 latched -> out_result holds 0x12, in_ready=0, next input not taken.
- SUB giving 0 (in_z=1, flag_we=1), then BRZ target 0x40 -> redirect_valid one cycle, redirect_pc=0x40; with flags z=0 -> no redirect.
- Jump to 0x80 followed by ADD writing r3 -> ADD killed: out_reg_we stays 0, flags unchanged, single redirect pulse.
- BRN with in_flag_we=1, in_n=1, stored flag_n=0 -> not taken, flag_n becomes 1 after.
